// File: rtl/gpio_irq.sv
// Wishbone GPIO with 1..64 tristate pins, two-flop input synchronizer and
// per-pin rising/falling edge interrupt capture (W1C status, level irq_o).
module gpio_irq #(
    parameter int                    GPIO_WIDTH   = 32,
    parameter logic [GPIO_WIDTH-1:0] DIR_RESET    = '0,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET    = '0,
    parameter int                    WB_ADR_WIDTH = 6
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
    input  logic [7:0]              wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [7:0]              wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    inout  wire  [GPIO_WIDTH-1:0]   gpio_io,
    output logic                    irq_o
);

    typedef enum logic [2:0] {
        GRP_DATA    = 3'd0,
        GRP_DIR     = 3'd1,
        GRP_SET     = 3'd2,
        GRP_CLR     = 3'd3,
        GRP_RISE_EN = 3'd4,
        GRP_FALL_EN = 3'd5,
        GRP_STATUS  = 3'd6,
        GRP_RSVD    = 3'd7
    } grp_e;

    logic [GPIO_WIDTH-1:0] dir_q, dir_d, out_q, out_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d;
    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [7:0]            dat_q, dat_d;
    logic                  ack_q, ack_d;

    logic                  acc, wr, adr_hi_ok;
    grp_e                  grp;
    logic [2:0]            byte_idx;
    logic [GPIO_WIDTH-1:0] wmask, wbits, rd_vec, edge_set;
    logic [7:0]            rdat;
    logic                  unused_ok;

    // Address bits above the 64-byte window must be zero to hit this block.
    if (WB_ADR_WIDTH > 6) begin : g_adr_hi
        assign adr_hi_ok = ~|wb_adr_i[WB_ADR_WIDTH-1:6];
    end else begin : g_adr_exact
        assign adr_hi_ok = 1'b1;
    end

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pad
        assign gpio_io[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

    assign unused_ok = ^{wb_cti_i, wb_bte_i};

    always_comb begin
        acc      = wb_cyc_i & wb_stb_i & ~ack_q;
        wr       = acc & wb_we_i & adr_hi_ok;
        grp      = grp_e'(wb_adr_i[5:3]);
        byte_idx = wb_adr_i[2:0];

        // Pins outside the addressed byte (or beyond GPIO_WIDTH) never see the write.
        wmask = '0;
        wbits = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            wmask[i] = (i[5:3] == byte_idx);
            wbits[i] = wmask[i] & wb_dat_i[i[2:0]];
        end

        case (grp)
            GRP_DATA:           rd_vec = (out_q & dir_q) | (sync2_q & ~dir_q);
            GRP_DIR:            rd_vec = dir_q;
            GRP_SET, GRP_CLR:   rd_vec = out_q;
            GRP_RISE_EN:        rd_vec = rise_en_q;
            GRP_FALL_EN:        rd_vec = fall_en_q;
            GRP_STATUS:         rd_vec = status_q;
            default:            rd_vec = '0;
        endcase

        rdat = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (wmask[i] && adr_hi_ok) rdat[i[2:0]] = rd_vec[i];
        end

        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr) begin
            case (grp)
                GRP_DATA:    out_d     = (out_q & ~wmask) | wbits;
                GRP_DIR:     dir_d     = (dir_q & ~wmask) | wbits;
                GRP_SET:     out_d     = out_q | wbits;
                GRP_CLR:     out_d     = out_q & ~wbits;
                GRP_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wbits;
                GRP_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wbits;
                default:     ;
            endcase
        end

        sync1_d = gpio_io;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // A new enabled edge beats a W1C landing on the same cycle.
        edge_set = ((sync2_q & ~prev_q) & rise_en_q) | ((~sync2_q & prev_q) & fall_en_q);
        status_d = status_q;
        if (wr && grp == GRP_STATUS) status_d = status_q & ~wbits;
        status_d = status_d | edge_set;

        ack_d = acc;
        dat_d = acc ? rdat : dat_q;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            dir_q     <= DIR_RESET;
            out_q     <= OUT_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign irq_o    = |status_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq (20 pins): bus reads are scored by a monitor
// that pops expected read data on every acknowledge.
module tb_gpio_irq;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [5:0]  wb_adr;
    logic [7:0]  wb_dat_w;
    logic        wb_we, wb_cyc, wb_stb;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o, irq_o;
    wire  [19:0] pads;
    logic [19:0] tb_drv, tb_en;

    typedef struct {
        logic       chk;
        logic [7:0] exp;
        string      nm;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  total = 0;
    int  bad   = 0;

    always #5 wb_clk = ~wb_clk;

    for (genvar g = 0; g < 20; g++) begin : g_drv
        assign pads[g] = tb_en[g] ? tb_drv[g] : 1'bz;
    end

    gpio_irq #(
        .GPIO_WIDTH  (20),
        .DIR_RESET   (20'h0000F),
        .OUT_RESET   (20'h00005),
        .WB_ADR_WIDTH(6)
    ) dut (
        .wb_clk  (wb_clk),
        .wb_rst_n(wb_rst_n),
        .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat_w),
        .wb_we_i (wb_we),
        .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb),
        .wb_cti_i(3'b000),
        .wb_bte_i(2'b00),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o),
        .gpio_io (pads),
        .irq_o   (irq_o)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a clock edge; the access is accepted on the next edge.
    task automatic bus(input logic [5:0] adr, input logic we, input logic [7:0] dat,
                       input logic [7:0] exp, input string nm);
        sb_q.push_back('{chk: !we, exp: exp, nm: nm});
        wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge wb_clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge wb_clk); #1;
    endtask

    task automatic step();
        @(posedge wb_clk); #1;
    endtask

    always @(negedge wb_clk) begin
        if (wb_rst_n && wb_ack_o) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard, want none");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) check(mon_e.nm, {24'h0, wb_dat_o}, {24'h0, mon_e.exp});
            end
        end
    end

    initial begin
        wb_rst_n = 1'b0; wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tb_en = 20'hFFFF0; tb_drv = '0;
        repeat (2) step();
        check("rst_ack", wb_ack_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_pads", pads[3:0], 4'b0101);
        check("err_rty", {wb_err_o, wb_rty_o}, 0);
        wb_rst_n = 1'b1;
        repeat (4) step();

        bus(6'h0A, 0, 8'h00, 8'h00, "rd_dir_b2");
        bus(6'h03, 0, 8'h00, 8'h00, "rd_oob_b3");
        bus(6'h08, 0, 8'h00, 8'h0F, "rd_dir_b0");
        bus(6'h00, 0, 8'h00, 8'h05, "rd_data_b0");

        // byte0 becomes all outputs
        tb_en = 20'hFFF00;
        bus(6'h08, 1, 8'hFF, 8'h00, "wr_dir");
        bus(6'h00, 1, 8'h0F, 8'h00, "wr_data");
        bus(6'h10, 1, 8'h30, 8'h00, "wr_set");
        bus(6'h18, 1, 8'h01, 8'h00, "wr_clr");
        check("pads_3e", pads[7:0], 8'h3E);
        bus(6'h00, 0, 8'h00, 8'h3E, "rd_data_3e");
        bus(6'h10, 0, 8'h00, 8'h3E, "rd_set_3e");
        bus(6'h18, 0, 8'h00, 8'h3E, "rd_clr_3e");

        // pad-to-read latency on byte1
        bus(6'h01, 0, 8'h00, 8'h00, "rd_b1_init");
        tb_drv[15:8] = 8'hA5;
        step();
        bus(6'h01, 0, 8'h00, 8'h00, "rd_b1_k1_old");
        tb_drv[15:8] = 8'h5A;
        step(); step();
        bus(6'h01, 0, 8'h00, 8'h5A, "rd_b1_k2_new");
        tb_drv[15:8] = 8'h00;
        repeat (4) step();

        bus(6'h21, 1, 8'h02, 8'h00, "wr_rise_en");
        bus(6'h28, 1, 8'h04, 8'h00, "wr_fall_en");
        bus(6'h21, 0, 8'h00, 8'h02, "rd_rise_en");
        bus(6'h28, 0, 8'h00, 8'h04, "rd_fall_en");
        check("irq_idle", irq_o, 0);

        tb_drv[9] = 1'b1;
        step(); step();
        check("irq_pin9_early", irq_o, 0);
        step();
        check("irq_pin9", irq_o, 1);
        tb_drv[9] = 1'b0;
        repeat (4) step();
        bus(6'h31, 0, 8'h00, 8'h02, "st_b1_pin9");
        bus(6'h30, 0, 8'h00, 8'h00, "st_b0_none");

        // pin 2 is an output; its falling edge is still captured
        bus(6'h18, 1, 8'h04, 8'h00, "clr_pin2");
        check("pads_3a", pads[7:0], 8'h3A);
        repeat (4) step();
        bus(6'h30, 0, 8'h00, 8'h04, "st_b0_pin2");
        bus(6'h31, 0, 8'h00, 8'h02, "st_b1_keep");
        bus(6'h31, 1, 8'h02, 8'h00, "w1c_pin9");
        bus(6'h31, 0, 8'h00, 8'h00, "st_b1_clr");
        bus(6'h30, 0, 8'h00, 8'h04, "st_b0_left");
        check("irq_still", irq_o, 1);
        bus(6'h30, 1, 8'h04, 8'h00, "w1c_pin2");
        check("irq_cleared", irq_o, 0);

        // rising edge of pin 9 captured on the same edge as its W1C
        tb_drv[9] = 1'b1;
        step(); step();
        bus(6'h31, 1, 8'h02, 8'h00, "w1c_race");
        bus(6'h31, 0, 8'h00, 8'h02, "st_race_set");
        check("irq_race", irq_o, 1);

        // strobe held: one ack every other cycle, then reset during ack
        repeat (3) sb_q.push_back('{chk: 1'b1, exp: 8'h02, nm: "hold_rd"});
        wb_adr = 6'h31; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk);
            check($sformatf("hold_ack%0d", i), wb_ack_o, i % 2);
        end
        #2;
        wb_rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        check("rst_mid_ack", wb_ack_o, 0);
        check("rst_mid_irq", irq_o, 0);
        step();
        wb_rst_n = 1'b1;
        repeat (2) step();
        bus(6'h08, 0, 8'h00, 8'h0F, "post_rst_dir");
        bus(6'h31, 0, 8'h00, 8'h00, "post_rst_st");
        bus(6'h21, 0, 8'h00, 8'h00, "post_rst_ren");
        check("post_rst_pads", pads[3:0], 4'b0101);

        repeat (2) step();
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised Wishbone GPIO peripheral for the board SoC, the successor to the fixed 8-bit GPIO. It sits on the 8-bit Wishbone peripheral bus and provides:
- 1 to 64 tristate pins, with per-byte data, direction and atomic set/clear registers.
- A two-flop input synchronizer.
- Per-pin rising/falling-edge interrupt capture with write-1-to-clear status.
- A single level interrupt output to the PIC.

## Interface
Parameters:
- GPIO_WIDTH, 32, number of pins (1..64)
- DIR_RESET, 0, reset value of direction register (bit=1 → output)
- OUT_RESET, 0, reset value of output register
- WB_ADR_WIDTH, 6, byte address width (64 bytes decoded)

Ports:
- wb_clk  in  1  Clock. One clock domain only.
- wb_rst_n  in  1  Reset. Asynchronous assert, active-low.
- wb_adr_i  in  WB_ADR_WIDTH  byte address
- wb_dat_i  in  8  write data
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  ignored; every access is treated as classic
- wb_bte_i  in  2  ignored
- wb_dat_o  out  8  registered read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  tied 0
- wb_rty_o  out  1  tied 0
- gpio_io  inout  GPIO_WIDTH  pads
- irq_o  out  1  interrupt, active-high level

## Operation
Register map:
- Address = group*8 + byte. Byte b covers pins [8b+7:8b].
- Bytes with b ≥ ceil(GPIO_WIDTH/8) read 0 and ignore writes.
- Bits above GPIO_WIDTH-1 in the last byte read 0 and ignore writes.

Groups:
- 0 DATA: write sets gpio_o. Read returns gpio_o for dir=1 pins and the synchronized pad value for dir=0 pins.
- 1 DIR: read/write; 1 = drive. Not inverted.
- 2 OUT_SET: write gpio_o |= wb_dat_i. Read returns gpio_o.
- 3 OUT_CLR: write gpio_o &= ~wb_dat_i. Read returns gpio_o.
- 4 RISE_EN: read/write per-pin rising-edge interrupt enable.
- 5 FALL_EN: read/write per-pin falling-edge interrupt enable.
- 6 IRQ_STATUS: read returns status. Writing 1 clears the bit; writing 0 has no effect.
- 7 reserved: reads 0, writes ignored.

Pads and interrupt logic:
- Each pad is driven with gpio_o[i] when dir[i]=1, otherwise high-Z.
- Synchronizer: sync1 <= gpio_io, sync2 <= sync1, prev <= sync2. This path applies to every pin regardless of direction.
- rise[i] = sync2[i] & ~prev[i]; fall[i] = ~sync2[i] & prev[i].
- status[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- If a set and a W1C clear hit the same bit on the same edge, the set wins.
- irq_o = |status. It is combinational from registered status, so there is no glitch source.
- Disabling an enable does not clear existing status.

Bus access:
- An access is accepted when wb_cyc_i & wb_stb_i & !wb_ack_o.
- On that clock edge: the write is committed, wb_dat_o is loaded, and wb_ack_o rises.
- On the next edge wb_ack_o falls.
- The result is exactly one ack per access and back-to-back accesses every 2 cycles.

Reset values (on wb_rst_n low, asynchronous):
- dir=DIR_RESET, gpio_o=OUT_RESET
- RISE_EN=0, FALL_EN=0, status=0
- sync1, sync2, prev = 0
- wb_dat_o=0, wb_ack_o=0, irq_o=0

Reset mid-transfer drops the ack. No write from an unacknowledged access is committed.

## Timing
- Write latency: a register or pad change is visible one cycle after the accepting edge, together with wb_ack_o=1.
- Read latency: wb_dat_o is valid in the wb_ack_o=1 cycle. Data is sampled at the accepting edge.
- Pad-to-DATA read: a pad change stable before edge k appears in sync2 after edge k+1. A read accepted at edge ≥ k+2 returns the new value.
- Pad-to-irq: status and irq_o assert after edge k+2.
- Edges on the pad are detected whether the pin is an input or an output.
- W1C: status clears after the accepting edge, unless a new enabled edge occurs on that same edge.
- At reset release with the pad high, sync2 rises 0→1. This is captured only if RISE_EN is already 1, which is impossible because enables reset to 0.

## Test plan
- Reset with GPIO_WIDTH=20, DIR_RESET=20'h0000F, OUT_RESET=20'h00005 → pads[3:0]=4'b0101 driven, pads[19:4]=Z. Read addr 0x0A (DIR byte 2) → 0x00. Read addr 0x03 (beyond ceil(20/8)=3 bytes) → 0x00.
- DIR byte0=0xFF, write DATA byte0=0x0F, write OUT_SET byte0=0x30, write OUT_CLR byte0=0x01 → pads[7:0]=0x3E. Reads of addr 0, 0x10 and 0x18 each return 0x3E.
- DIR=0, drive pads byte1=0xA5 at edge k → read of addr 1 accepted at edge k+1 returns the old value; read accepted at edge k+2 returns 0xA5.
- RISE_EN pin 9=1, FALL_EN pin 2=1. Pulse pin 9 high, then drive pin 2 low → status byte1=0x02, status byte0=0x04, irq_o=1 three edges after each pad change. Write 0x02 to addr 0x31 → only pin 9 is cleared and irq_o stays 1.
- Pin 9 rising edge lands on the same edge as a W1C of bit 9 → status bit 9 remains 1.
- Hold wb_stb_i high for 6 cycles → wb_ack_o toggles 0,1,0,1,0,1. Assert wb_rst_n=0 while wb_ack_o=1 → wb_ack_o=0 immediately and no register changes.
